rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies MMCM lock, holds core reset, then releases.
// Tracks lock timeout and counts lock losses seen while running.
module rst_seq_ctrl #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned RST_HOLD_CYCLES     = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_100M,
    input  logic       rst,
    input  logic       mmcm_locked,
    input  logic       sw_rst_req,
    output logic       core_rst,
    output logic       core_ready,
    output logic       lock_timeout,
    output logic [7:0] lock_lost_cnt,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        STABLE    = 2'b01,
        HOLD      = 2'b10,
        RUN       = 2'b11
    } state_e;

    localparam int unsigned MAX_AB =
        (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned MAXP =
        (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          locked_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    lost_q, lost_d;
    logic          core_rst_q;
    logic          core_ready_q;

    assign locked_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        tmo_d   = tmo_q;
        lost_d  = lost_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end else begin
                    if (tcnt_q != TMO_LAST)
                        tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_d == TMO_LAST)
                        tmo_d = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                // lock loss wins over a simultaneous soft reset request
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    if (lost_q != 8'hFF)
                        lost_d = lost_q + 8'd1;
                end else if (sw_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            tmo_q        <= 1'b0;
            lost_q       <= 8'd0;
            core_rst_q   <= 1'b1;
            core_ready_q <= 1'b0;
        end else begin
            sync1_q      <= mmcm_locked;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            tmo_q        <= tmo_d;
            lost_q       <= lost_d;
            core_rst_q   <= (state_d != RUN);
            core_ready_q <= (state_d == RUN);
        end
    end

    assign core_rst      = core_rst_q;
    assign core_ready    = core_ready_q;
    assign lock_timeout  = tmo_q;
    assign lock_lost_cnt = lost_q;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: vector table, saturation run and random
// stimulus against a deadline-based reference model.
module tb_rst_seq_ctrl;

    localparam int LS = 8;
    localparam int RH = 4;
    localparam int LT = 32;

    logic       clk;
    logic       rst;
    logic       mmcm_locked;
    logic       sw_rst_req;
    logic       core_rst;
    logic       core_ready;
    logic       lock_timeout;
    logic [7:0] lock_lost_cnt;
    logic [1:0] seq_state;

    int checks;
    int errors;

    rst_seq_ctrl #(
        .LOCK_STABLE_CYCLES (LS),
        .RST_HOLD_CYCLES    (RH),
        .LOCK_TIMEOUT_CYCLES(LT)
    ) dut (
        .clk_100M     (clk),
        .rst          (rst),
        .mmcm_locked  (mmcm_locked),
        .sw_rst_req   (sw_rst_req),
        .core_rst     (core_rst),
        .core_ready   (core_ready),
        .lock_timeout (lock_timeout),
        .lock_lost_cnt(lock_lost_cnt),
        .seq_state    (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase plus absolute-edge deadlines
    int   m_edge;
    int   m_phase;
    int   m_deadline;
    int   m_wait_start;
    logic m_tmo;
    int   m_lost;
    logic hist[$];

    task automatic model_step(input logic r, input logic l, input logic s);
        logic ls;
        m_edge++;
        if (r) begin
            m_phase      = 0;
            m_wait_start = m_edge;
            m_tmo        = 1'b0;
            m_lost       = 0;
            hist         = {1'b0, 1'b0};
            return;
        end
        ls = hist.pop_front();
        hist.push_back(l);
        case (m_phase)
            0: begin
                if (ls) begin
                    m_phase    = 1;
                    m_deadline = m_edge + LS;
                end else if (m_edge - m_wait_start >= LT - 1) begin
                    m_tmo = 1'b1;
                end
            end
            1: begin
                if (!ls) begin
                    m_phase      = 0;
                    m_wait_start = m_edge;
                end else if (m_edge == m_deadline) begin
                    m_phase    = 2;
                    m_deadline = m_edge + RH;
                end
            end
            2: begin
                if (!ls) begin
                    m_phase      = 0;
                    m_wait_start = m_edge;
                end else if (m_edge == m_deadline) begin
                    m_phase = 3;
                end
            end
            default: begin
                if (!ls) begin
                    m_phase      = 0;
                    m_wait_start = m_edge;
                    if (m_lost < 255) m_lost++;
                end else if (s) begin
                    m_phase    = 2;
                    m_deadline = m_edge + RH;
                end
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic l, input logic s);
        logic [12:0] act;
        logic [12:0] exp;
        rst         = r;
        mmcm_locked = l;
        sw_rst_req  = s;
        @(posedge clk);
        model_step(r, l, s);
        #1;
        act = {core_rst, core_ready, lock_timeout, lock_lost_cnt, seq_state};
        exp = {m_phase != 3, m_phase == 3, m_tmo, 8'(m_lost), 2'(m_phase)};
        chk("model", 32'(act), 32'(exp));
    endtask

    typedef struct {
        logic       r;
        logic       lk;
        logic       sw;
        int         n;
        logic [1:0] st;
        logic       crst;
        logic       tmo;
        logic [7:0] lost;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic lk, input logic sw,
                                input int n, input logic [1:0] st,
                                input logic crst, input logic tmo,
                                input logic [7:0] lost);
        vec_t v;
        v.r = r; v.lk = lk; v.sw = sw; v.n = n;
        v.st = st; v.crst = crst; v.tmo = tmo; v.lost = lost;
        return v;
    endfunction

    initial begin
        logic lk;
        checks      = 0;
        errors      = 0;
        m_edge      = 0;
        m_phase     = 0;
        m_deadline  = 0;
        m_wait_start = 0;
        m_tmo       = 1'b0;
        m_lost      = 0;
        hist        = {1'b0, 1'b0};
        rst         = 1'b1;
        mmcm_locked = 1'b0;
        sw_rst_req  = 1'b0;

        tbl.push_back(mk(1, 0, 0,  2, 2'd0, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  2, 2'd0, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  1, 2'd1, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  7, 2'd1, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  1, 2'd2, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  3, 2'd2, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  1, 2'd3, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 1,  1, 2'd2, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  3, 2'd2, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  1, 2'd3, 0, 0, 8'd0));
        tbl.push_back(mk(0, 0, 0,  2, 2'd3, 0, 0, 8'd0));
        tbl.push_back(mk(0, 0, 0,  1, 2'd0, 1, 0, 8'd1));
        tbl.push_back(mk(0, 1, 0,  5, 2'd1, 1, 0, 8'd1));
        tbl.push_back(mk(0, 0, 0,  2, 2'd1, 1, 0, 8'd1));
        tbl.push_back(mk(0, 0, 0,  1, 2'd0, 1, 0, 8'd1));
        tbl.push_back(mk(0, 1, 0,  3, 2'd1, 1, 0, 8'd1));
        tbl.push_back(mk(0, 1, 1,  1, 2'd1, 1, 0, 8'd1));
        tbl.push_back(mk(0, 1, 0,  6, 2'd1, 1, 0, 8'd1));
        tbl.push_back(mk(0, 1, 0,  1, 2'd2, 1, 0, 8'd1));
        tbl.push_back(mk(0, 1, 0,  4, 2'd3, 0, 0, 8'd1));
        tbl.push_back(mk(0, 0, 0,  2, 2'd3, 0, 0, 8'd1));
        tbl.push_back(mk(0, 0, 1,  1, 2'd0, 1, 0, 8'd2));
        tbl.push_back(mk(0, 0, 0, 30, 2'd0, 1, 0, 8'd2));
        tbl.push_back(mk(0, 0, 0,  1, 2'd0, 1, 1, 8'd2));
        tbl.push_back(mk(0, 0, 0,  8, 2'd0, 1, 1, 8'd2));
        tbl.push_back(mk(0, 1, 0, 15, 2'd3, 0, 1, 8'd2));
        tbl.push_back(mk(0, 1, 1,  1, 2'd2, 1, 1, 8'd2));
        tbl.push_back(mk(1, 1, 0,  1, 2'd0, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0,  1, 2'd0, 1, 0, 8'd0));

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++)
                tick(tbl[i].r, tbl[i].lk, tbl[i].sw);
            chk($sformatf("vec%0d_state", i), 32'(seq_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_core_rst", i), 32'(core_rst), 32'(tbl[i].crst));
            chk($sformatf("vec%0d_ready", i), 32'(core_ready), 32'(!tbl[i].crst));
            chk($sformatf("vec%0d_timeout", i), 32'(lock_timeout), 32'(tbl[i].tmo));
            chk($sformatf("vec%0d_lost", i), 32'(lock_lost_cnt), 32'(tbl[i].lost));
        end

        // 256 lock losses from RUN: count must saturate at 255
        tick(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 256; j++) begin
            for (int k = 0; k < 15; k++) tick(1'b0, 1'b1, 1'b0);
            if (j == 0) chk("sat_first_run", 32'(seq_state), 32'd3);
            for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0);
            if (j == 0) chk("sat_first_loss", 32'(lock_lost_cnt), 32'd1);
        end
        chk("sat_lost", 32'(lock_lost_cnt), 32'd255);
        chk("sat_state", 32'(seq_state), 32'd0);

        // random stimulus against the model
        tick(1'b1, 1'b0, 1'b0);
        lk = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) lk = ~lk;
            tick($urandom_range(0, 599) == 0, lk, $urandom_range(0, 11) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
